// File: rtl/fifo_word_serializer_if.sv
// Interface for the word serializer. It carries the FIFO read port (fifo_empty,
// fifo_dout, fifo_rn) and the byte stream output (out_data, out_valid,
// out_ready, out_last) together with the busy and words_sent status outputs.
//   master : the serializer side (drives fifo_rn and all out_*/status outputs)
//   slave  : the environment side (drives fifo_empty, fifo_dout, out_ready)
interface fifo_word_serializer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_rn;
   logic [BYTE_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
   logic                  busy;
   logic [CNT_WIDTH-1:0]  words_sent;

   modport master (
      input  fifo_empty, fifo_dout, out_ready,
      output fifo_rn, out_data, out_valid, out_last, busy, words_sent
   );

   modport slave (
      output fifo_empty, fifo_dout, out_ready,
      input  fifo_rn, out_data, out_valid, out_last, busy, words_sent
   );
endinterface

// File: rtl/fifo_word_serializer.sv
// Pops one word at a time from a synchronous FIFO read port and emits it as a
// stream of BYTE_WIDTH symbols on a valid/ready output.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : fifo_word_serializer_if master modport
//           fifo_empty/fifo_dout in, fifo_rn out   (FIFO read side)
//           out_data/out_valid/out_last out, out_ready in (byte stream)
//           busy, words_sent out                   (status)
// All outputs are decoded from registers only.
module fifo_word_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int MSB_FIRST  = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic clock,
   input  logic reset,
   fifo_word_serializer_if.master bus
);
   localparam int N     = DATA_WIDTH / BYTE_WIDTH;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_WAIT = 2'd2,
      ST_SEND = 2'd3
   } state_t;

   state_t                state_q,  state_d;
   logic [DATA_WIDTH-1:0] shift_q,  shift_d;
   logic [IDX_W-1:0]      idx_q,    idx_d;
   logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;

   // Byte lanes listed in transmission order, so the byte index selects the
   // lane directly regardless of MSB_FIRST.
   logic [BYTE_WIDTH-1:0] lane_w [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      if (MSB_FIRST != 0) begin : g_msb
         assign lane_w[gi] = shift_q[DATA_WIDTH-1-gi*BYTE_WIDTH -: BYTE_WIDTH];
      end else begin : g_lsb
         assign lane_w[gi] = shift_q[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shift_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (!bus.fifo_empty) begin
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // fifo_dout carries the popped word in this cycle.
            shift_d = bus.fifo_dout;
            idx_d   = '0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (bus.out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  cnt_d   = cnt_q + CNT_WIDTH'(1);
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs, decoded from registered state only
   always_comb begin
      bus.fifo_rn    = (state_q == ST_READ);
      bus.out_valid  = (state_q == ST_SEND);
      bus.out_last   = (state_q == ST_SEND) && (idx_q == LAST_IDX);
      bus.busy       = (state_q != ST_IDLE);
      bus.out_data   = lane_w[idx_q];
      bus.words_sent = cnt_q;
   end
endmodule

// File: tb/tb_fifo_word_serializer.sv
module tb_fifo_word_serializer;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   fifo_word_serializer_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .CNT_WIDTH(16)) bus0 ();
   fifo_word_serializer_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .CNT_WIDTH(2))  bus1 ();

   fifo_word_serializer #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(16)) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0.master)
   );

   fifo_word_serializer #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(2)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1.master)
   );

   assign bus1.out_ready = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // FIFO contents and expected byte streams ({last, byte})
   logic [31:0] fifo0_q [$];
   logic [31:0] fifo1_q [$];
   logic [8:0]  exp0_q  [$];
   logic [8:0]  exp1_q  [$];
   int rn_cnt0   = 0;
   int rn_empty0 = 0;
   int rn_empty1 = 0;

   task automatic push0(input logic [31:0] w);
      fifo0_q.push_back(w);
      for (int i = 0; i < 4; i++) exp0_q.push_back({(i == 3), w[31-8*i -: 8]});
   endtask

   task automatic push1(input logic [31:0] w);
      fifo1_q.push_back(w);
      for (int i = 0; i < 4; i++) exp1_q.push_back({(i == 3), w[8*i +: 8]});
   endtask

   // FIFO models: a high fifo_rn in this cycle pops at the coming edge, so the
   // word is presented on fifo_dout for the following cycle.
   always @(negedge clock) begin : fifo0_model
      if (bus0.fifo_rn === 1'b1) begin
         rn_cnt0++;
         if (fifo0_q.size() == 0) rn_empty0++;
         else bus0.fifo_dout = fifo0_q.pop_front();
      end
      bus0.fifo_empty = (fifo0_q.size() == 0);
   end

   always @(negedge clock) begin : fifo1_model
      if (bus1.fifo_rn === 1'b1) begin
         if (fifo1_q.size() == 0) rn_empty1++;
         else bus1.fifo_dout = fifo1_q.pop_front();
      end
      bus1.fifo_empty = (fifo1_q.size() == 0);
   end

   // Output monitors: one comparison pair per accepted byte
   always @(negedge clock) begin : mon0
      logic [8:0] e;
      if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
         if (exp0_q.size() == 0) begin
            check_val("extra_byte0", 32'(bus0.out_data), 32'hFFFF_FFFF);
         end else begin
            e = exp0_q.pop_front();
            check_val("byte0", 32'(bus0.out_data), 32'(e[7:0]));
            check_val("last0", 32'(bus0.out_last), 32'(e[8]));
         end
      end
   end

   always @(negedge clock) begin : mon1
      logic [8:0] e;
      if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
         if (exp1_q.size() == 0) begin
            check_val("extra_byte1", 32'(bus1.out_data), 32'hFFFF_FFFF);
         end else begin
            e = exp1_q.pop_front();
            check_val("byte1", 32'(bus1.out_data), 32'(e[7:0]));
            check_val("last1", 32'(bus1.out_last), 32'(e[8]));
         end
      end
   end

   task automatic wait_words0(input string tag, input logic [15:0] target);
      int k = 0;
      while (bus0.words_sent !== target && k < 200) begin
         @(negedge clock);
         k++;
      end
      check_val(tag, 32'(bus0.words_sent), 32'(target));
   endtask

   initial begin
      int lat;
      int acc;
      int k;
      bus0.out_ready = 1'b1;
      reset = 1'b0;

      // Reset held with a non-empty FIFO
      push0(32'h0A0B0C0D);
      repeat (3) @(negedge clock);
      check_val("rst_rn",    32'(bus0.fifo_rn),    32'h0);
      check_val("rst_valid", 32'(bus0.out_valid),  32'h0);
      check_val("rst_last",  32'(bus0.out_last),   32'h0);
      check_val("rst_busy",  32'(bus0.busy),       32'h0);
      check_val("rst_data",  32'(bus0.out_data),   32'h0);
      check_val("rst_words", 32'(bus0.words_sent), 32'h0);
      check_val("rst_words1", 32'(bus1.words_sent), 32'h0);

      // Single word: latency and consecutive bytes
      @(posedge clock); #1 reset = 1'b1;
      lat = 0;
      while (bus0.out_valid !== 1'b1 && lat < 20) begin
         @(negedge clock);
         if (bus0.out_valid !== 1'b1) lat++;
      end
      check_val("latency", 32'(lat), 32'd3);
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) acc++;
         @(negedge clock);
      end
      check_val("consecutive", 32'(acc), 32'd4);
      wait_words0("words_t2", 16'd1);
      check_val("rn_t2", 32'(rn_cnt0), 32'd1);

      // Back-to-back words
      @(posedge clock); #1;
      push0(32'd10); push0(32'd15); push0(32'd20); push0(32'd30);
      push0(32'd35); push0(32'd40); push0(32'd45);
      wait_words0("words_t3", 16'd8);
      repeat (5) @(negedge clock);
      check_val("rn_t3",       32'(rn_cnt0),      32'd8);
      check_val("rn_empty",    32'(rn_empty0),    32'd0);
      check_val("idle_busy",   32'(bus0.busy),    32'h0);
      check_val("idle_rn",     32'(bus0.fifo_rn), 32'h0);

      // Backpressure on the second byte
      @(posedge clock); #1;
      push0(32'h11223344);
      k = 0;
      while (!(bus0.out_valid === 1'b1 && bus0.out_data === 8'h11) && k < 50) begin
         @(negedge clock);
         k++;
      end
      check_val("t4_first", 32'(bus0.out_data), 32'h11);
      @(posedge clock); #1 bus0.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check_val("stall_valid", 32'(bus0.out_valid), 32'h1);
         check_val("stall_data",  32'(bus0.out_data),  32'h22);
         check_val("stall_last",  32'(bus0.out_last),  32'h0);
      end
      @(posedge clock); #1 bus0.out_ready = 1'b1;
      wait_words0("words_t4", 16'd9);

      // Reset in the middle of a word
      @(posedge clock); #1;
      push0(32'hDEADBEEF);
      push0(32'h01020304);
      k = 0;
      while (!(bus0.out_valid === 1'b1 && bus0.out_data === 8'hAD) && k < 50) begin
         @(negedge clock);
         k++;
      end
      check_val("t5_second", 32'(bus0.out_data), 32'hAD);
      @(posedge clock); #1 reset = 1'b0;
      #1;
      check_val("mid_rst_valid", 32'(bus0.out_valid),  32'h0);
      check_val("mid_rst_busy",  32'(bus0.busy),       32'h0);
      check_val("mid_rst_words", 32'(bus0.words_sent), 32'h0);
      // The interrupted word is discarded: drop its remaining expected bytes.
      while (exp0_q.size() != 0 && exp0_q[0][8] == 1'b0) void'(exp0_q.pop_front());
      if (exp0_q.size() != 0) void'(exp0_q.pop_front());
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      wait_words0("words_t5", 16'd1);
      check_val("rn_t5", 32'(rn_cnt0), 32'd11);

      // LSB-first instance with a 2-bit wrapping counter
      @(posedge clock); #1;
      push1(32'hA1B2C3D4);
      push1(32'h00000001);
      push1(32'h55667788);
      push1(32'h99AABBCC);
      push1(32'hF0E0D0C0);
      k = 0;
      while ((exp1_q.size() != 0 || bus1.busy !== 1'b0) && k < 300) begin
         @(negedge clock);
         k++;
      end
      repeat (2) @(negedge clock);
      check_val("words_t6",  32'(bus1.words_sent), 32'd1);
      check_val("sb_left1",  32'(exp1_q.size()),   32'd0);
      check_val("rn_empty1", 32'(rn_empty1),       32'd0);
      check_val("sb_left0",  32'(exp0_q.size()),   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
